// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//
// Instruction-fetch sequencer. Owns the fetch PC, issues at most one
// outstanding request to instruction memory, and holds the returned
// instruction in a registered IF slot for decode.
//
// Next-PC priority: trap, then EX redirect, then sequential PC+4.
// A redirect flushes the IF slot (even under decode stall) and discards
// any response still in flight for the old path.
//
// Parameters
//   RESET_VECTOR  first fetch address after reset
//   NOP_INSTR     value of instr_if whenever the slot is empty
//
// Ports
//   clk, rst                 clock, async active-high reset
//   trap, trap_pc            trap redirect (highest priority) and target
//   redirect_ex, redirect_pc EX branch/jump redirect and target
//   stall_id                 decode cannot accept the IF slot this cycle
//   imem_req, imem_addr      request valid / word-aligned address
//   imem_ready               memory accepts the request this cycle
//   imem_rvalid, imem_rdata  response valid / data
//   if_valid                 IF slot holds a valid instruction
//   pc_if, pc_plus_four_if   PC of the slot instruction and PC+4
//   instr_if                 slot instruction (NOP_INSTR when empty)
// -----------------------------------------------------------------------------
module fetch_controller #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap,
  input  logic [31:0] trap_pc,
  input  logic        redirect_ex,
  input  logic [31:0] redirect_pc,
  input  logic        stall_id,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] pc_if,
  output logic [31:0] pc_plus_four_if,
  output logic [31:0] instr_if
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] fetch_pc;
  logic        redir;
  logic [31:0] redir_target;
  logic        slot_free;
  logic        resp_take;

  // Trap wins over EX redirect; the low two bits are cleared so every
  // fetch address stays word aligned.
  assign redir        = trap | redirect_ex;
  assign redir_target = (trap ? trap_pc : redirect_pc) & ~32'h0000_0003;

  // The slot can take a new instruction if it is empty or being consumed
  // by decode this cycle.
  assign slot_free = !if_valid || !stall_id;

  // A response is only written to the slot when we are waiting for it on
  // the current path; in DRAIN or under a redirect it belongs to a dead path.
  assign resp_take = (state == ST_WAIT) && imem_rvalid && !redir;

  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request gating is done only in REQ so that a request, once accepted,
  // is never duplicated and an unaccepted request keeps its address.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      ST_IDLE: begin
        state_next = ST_REQ;
      end
      ST_REQ: begin
        imem_req = slot_free && !redir;
        if (imem_req && imem_ready) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          state_next = ST_REQ;
        end else if (redir) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (imem_rvalid) begin
          state_next = ST_REQ;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Fetch PC: a redirect in any state retargets it; otherwise it only
  // advances when a response for the current path lands in the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_VECTOR;
    end else if (redir) begin
      fetch_pc <= redir_target;
    end else if (resp_take) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // IF slot. A flush or consumption empties it and parks NOP_INSTR on
  // instr_if; pc_if keeps its last value since if_valid qualifies it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid        <= 1'b0;
      pc_if           <= RESET_VECTOR;
      pc_plus_four_if <= RESET_VECTOR + 32'd4;
      instr_if        <= NOP_INSTR;
    end else if (redir) begin
      if_valid <= 1'b0;
      instr_if <= NOP_INSTR;
    end else if (resp_take) begin
      if_valid        <= 1'b1;
      pc_if           <= fetch_pc;
      pc_plus_four_if <= fetch_pc + 32'd4;
      instr_if        <= imem_rdata;
    end else if (if_valid && !stall_id) begin
      if_valid <= 1'b0;
      instr_if <= NOP_INSTR;
    end
  end

endmodule
